// File: rtl/boot_uploader_if.sv
`default_nettype none
// ============================================================================
// Module   : boot_uploader_if
// Brief    : ROM fetch and UART byte channels between boot_uploader and system
// Revision : 1.0 - initial release
// ============================================================================
interface boot_uploader_if;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  tx_dat;
    logic        tx_dat_en;
    logic        tx_ready;
    logic [7:0]  rx_dat;
    logic        rx_dat_en;

    modport master (
        output rom_addr, tx_dat, tx_dat_en,
        input  rom_data, tx_ready, rx_dat, rx_dat_en
    );

    modport slave (
        input  rom_addr, tx_dat, tx_dat_en,
        output rom_data, tx_ready, rx_dat, rx_dat_en
    );
endinterface
`default_nettype wire

// File: rtl/boot_uploader.sv
`default_nettype none
// ============================================================================
// Module   : boot_uploader
// Brief    : Streams a 16-bit ROM image out over UART, optionally checks the
//            echoed image (define BOOT_UPLOADER_VERIFY_ECHO_EN).
// Revision : 1.0 - initial release
// ============================================================================
module boot_uploader #(
    parameter int N_WORDS      = 64,
    parameter int ECHO_TIMEOUT = 2000000
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              ce,
    input  wire              start,
    boot_uploader_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [6:0]       err_count
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_FETCH     = 3'd1;
    localparam logic [2:0] c_ST_LATCH     = 3'd2;
    localparam logic [2:0] c_ST_SEND_HI   = 3'd3;
    localparam logic [2:0] c_ST_SEND_LO   = 3'd4;
    localparam logic [2:0] c_ST_NEXT      = 3'd5;
    localparam logic [2:0] c_ST_WAIT_ECHO = 3'd6;
    localparam logic [2:0] c_ST_DONE      = 3'd7;

    localparam logic [5:0] c_LAST_IDX = 6'(N_WORDS - 1);

    logic [2:0]  r_state;
    logic [5:0]  r_word_idx;
    logic [15:0] r_word;
    logic        r_pass;
    logic        r_timeout;
    logic [6:0]  r_err_count;
    logic        w_send;

`ifdef BOOT_UPLOADER_VERIFY_ECHO_EN
    localparam int c_TMO_W = (ECHO_TIMEOUT > 1) ? $clog2(ECHO_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ECHO_TIMEOUT - 1);

    logic [5:0]         r_echo_idx;
    logic [7:0]         r_hi_byte;
    logic               r_have_hi;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_mismatch;
    logic [6:0]         w_err_next;

    assign w_mismatch = ({r_hi_byte, bus.rx_dat} != bus.rom_data);
    assign w_err_next = r_err_count + {6'd0, w_mismatch};
    // During echo the ROM is re-read at the echo index for the comparison.
    assign bus.rom_addr = (r_state == c_ST_WAIT_ECHO) ? r_echo_idx : r_word_idx;
`else
    logic w_unused_rx;
    assign w_unused_rx  = ^{bus.rx_dat, bus.rx_dat_en};
    assign bus.rom_addr = r_word_idx;
`endif

    // Strobe is combinational so ce=0 or a reset can never leave it asserted.
    assign w_send        = ce && bus.tx_ready &&
                           ((r_state == c_ST_SEND_HI) || (r_state == c_ST_SEND_LO));
    assign bus.tx_dat_en = w_send;
    assign bus.tx_dat    = (r_state == c_ST_SEND_HI) ? r_word[15:8] :
                           (r_state == c_ST_SEND_LO) ? r_word[7:0]  : 8'h00;

    assign busy      = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign done      = (r_state == c_ST_DONE);
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign err_count = r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_word_idx  <= 6'd0;
            r_word      <= 16'd0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= 7'd0;
`ifdef BOOT_UPLOADER_VERIFY_ECHO_EN
            r_echo_idx  <= 6'd0;
            r_hi_byte   <= 8'd0;
            r_have_hi   <= 1'b0;
            r_tmo_cnt   <= '0;
`endif
        end else if (ce) begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_word_idx  <= 6'd0;
                        r_err_count <= 7'd0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
`ifdef BOOT_UPLOADER_VERIFY_ECHO_EN
                        r_echo_idx  <= 6'd0;
                        r_have_hi   <= 1'b0;
`endif
                        r_state     <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: r_state <= c_ST_LATCH;
                c_ST_LATCH: begin
                    r_word  <= bus.rom_data;
                    r_state <= c_ST_SEND_HI;
                end
                c_ST_SEND_HI: if (bus.tx_ready) r_state <= c_ST_SEND_LO;
                c_ST_SEND_LO: if (bus.tx_ready) r_state <= c_ST_NEXT;
                c_ST_NEXT: begin
                    if (r_word_idx != c_LAST_IDX) begin
                        r_word_idx <= r_word_idx + 6'd1;
                        r_state    <= c_ST_FETCH;
                    end else begin
`ifdef BOOT_UPLOADER_VERIFY_ECHO_EN
                        r_echo_idx <= 6'd0;
                        r_have_hi  <= 1'b0;
                        r_tmo_cnt  <= '0;
                        r_state    <= c_ST_WAIT_ECHO;
`else
                        r_pass     <= 1'b1;
                        r_state    <= c_ST_DONE;
`endif
                    end
                end
`ifdef BOOT_UPLOADER_VERIFY_ECHO_EN
                c_ST_WAIT_ECHO: begin
                    // A byte arriving on the terminal count still wins.
                    if (bus.rx_dat_en) begin
                        r_tmo_cnt <= '0;
                        if (!r_have_hi) begin
                            r_hi_byte <= bus.rx_dat;
                            r_have_hi <= 1'b1;
                        end else begin
                            r_have_hi   <= 1'b0;
                            r_err_count <= w_err_next;
                            if (r_echo_idx == c_LAST_IDX) begin
                                r_pass  <= (w_err_next == 7'd0);
                                r_state <= c_ST_DONE;
                            end else begin
                                r_echo_idx <= r_echo_idx + 6'd1;
                            end
                        end
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
`endif
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
